// File: rtl/load_store_unit_if.sv
// Bus bundles for the load/store unit.
//   lsu_req_if : datapath-side request/response channel.
//                master = datapath (drives req_*), slave = load_store_unit.
//   lsu_mem_if : word-indexed data-memory channel.
//                master = load_store_unit (drives mem_addr/strobes/write data),
//                slave  = memory (returns mem_read_data combinationally).

interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

interface lsu_mem_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  modport master (
    output mem_addr, mem_write_data, mem_read, mem_write,
    input  mem_read_data
  );

  modport slave (
    input  mem_addr, mem_write_data, mem_read, mem_write,
    output mem_read_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts byte-addressed load/store requests and drives a
// word-indexed data memory. Handles byte/half/word sizes, sign/zero
// extension, little-endian lane selection and read-modify-write for
// sub-word stores. Misaligned, out-of-range and reserved-size requests are
// answered with an error response without touching memory.
// Ports:
//   clk, rst_n : clock (posedge) and asynchronous active-low reset
//   req_bus    : request/response channel (slave side)
//   mem_bus    : data-memory channel (master side)
// Parameter:
//   MEM_AW     : log2 of memory depth in 32-bit words

module load_store_unit #(
  parameter int unsigned MEM_AW = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  lsu_req_if.slave   req_bus,
  lsu_mem_if.master  mem_bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rword_q, rword_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        write_q, write_d;
  logic        err_q, err_d;

  logic        req_err;
  logic [31:0] lane_word;
  logic [31:0] load_val;
  logic [31:0] merged;

  always_comb begin
    req_err = 1'b0;
    if (req_bus.req_addr[31:MEM_AW+2] != '0) req_err = 1'b1;
    unique case (req_bus.req_size)
      2'b01:   if (req_bus.req_addr[0])          req_err = 1'b1;
      2'b10:   if (req_bus.req_addr[1:0] != '0)  req_err = 1'b1;
      2'b11:   req_err = 1'b1;
      default: ;
    endcase
  end

  // Next-state and request latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rword_d    = rword_q;
    mem_addr_d = mem_addr_q;
    size_d     = size_q;
    signed_d   = signed_q;
    write_d    = write_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: if (req_bus.req_valid) begin
        addr_d     = req_bus.req_addr;
        wdata_d    = req_bus.req_wdata;
        size_d     = req_bus.req_size;
        signed_d   = req_bus.req_signed;
        write_d    = req_bus.req_write;
        err_d      = req_err;
        mem_addr_d = {{(32-MEM_AW){1'b0}}, req_bus.req_addr[MEM_AW+1:2]};
        if (req_err)
          state_d = RESP;
        else if (req_bus.req_write && req_bus.req_size == 2'b10)
          state_d = WR;
        else
          state_d = RD;
      end
      RD: begin
        rword_d = mem_bus.mem_read_data;
        state_d = write_q ? WR : RESP;
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rword_q    <= '0;
      mem_addr_q <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rword_q    <= rword_d;
      mem_addr_q <= mem_addr_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      write_q    <= write_d;
      err_q      <= err_d;
    end
  end

  // Load lane: shift the addressed byte/half down to bit 0, then extend.
  always_comb begin
    lane_word = '0;
    load_val  = rword_q;
    unique case (size_q)
      2'b00: begin
        lane_word = rword_q >> {addr_q[1:0], 3'b000};
        load_val  = {{24{signed_q & lane_word[7]}}, lane_word[7:0]};
      end
      2'b01: begin
        lane_word = rword_q >> {addr_q[1], 4'b0000};
        load_val  = {{16{signed_q & lane_word[15]}}, lane_word[15:0]};
      end
      default: load_val = rword_q;
    endcase
  end

  // Store merge: sub-word stores overwrite one lane of the word read in RD.
  always_comb begin
    merged = rword_q;
    unique case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  // Strobes decode from the state register only, so reset drops them at once.
  always_comb begin
    req_bus.req_ready      = (state_q == IDLE);
    req_bus.resp_valid     = (state_q == RESP);
    req_bus.resp_error     = (state_q == RESP) && err_q;
    req_bus.resp_rdata     = (state_q == RESP && !err_q && !write_q) ? load_val : '0;
    mem_bus.mem_read       = (state_q == RD);
    mem_bus.mem_write      = (state_q == WR);
    mem_bus.mem_addr       = mem_addr_q;
    mem_bus.mem_write_data = (state_q == WR) ? merged : '0;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts byte-addressed load/store requests from the datapath and drives the word-indexed data memory (combinational read when read strobe high, write on posedge when write strobe high).
- Handles byte/halfword/word sizes, sign/zero extension, little-endian lane selection and read-modify-write for sub-word stores.
- Flags misaligned, out-of-range and reserved-size requests without touching memory.

Parameters:
MEM_AW, 10, log2 of memory depth in 32-bit words (1024 words = 4 KiB byte space)

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept; high only in IDLE
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result, extended; 0 for stores and errors
resp_error  out  1  valid with resp_valid; misaligned, out of range or size 11
mem_addr  out  32  word index = zero-extended req_addr[MEM_AW+1:2]
mem_write_data  out  32  merged store word
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_read_data  in  32  memory read data, valid combinationally while mem_read high

Behaviour:
- Reset (async, rst_n low): state IDLE; req_ready 1; resp_valid, resp_error, mem_read, mem_write 0; resp_rdata, mem_addr, mem_write_data 0. Asserting reset mid-transaction drops mem_read/mem_write immediately; no response is issued; an in-flight store may or may not have reached memory.
- States: IDLE, RD, WR, RESP.
- IDLE: req_ready=1. On req_valid: latch addr, size, signed, write and wdata.
  - Error check, in any of these cases: size 11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:MEM_AW+2] nonzero. Error goes to RESP with error=1 and no memory strobe.
  - Otherwise: a load or a sub-word store goes to RD; a word store goes to WR.
- RD: mem_read=1, mem_write=0. Capture mem_read_data into an internal register at the posedge leaving RD. Load goes to RESP; sub-word store goes to WR.
- WR: mem_write=1, mem_read=0. mem_write_data is valid for the whole cycle.
  - Word: wdata.
  - Byte: captured word with lane addr[1:0] (bits 8k+7:8k) replaced by wdata[7:0].
  - Half: lane addr[1] (bits 16h+15:16h) replaced by wdata[15:0].
  - Memory commits at the posedge leaving WR. Next state RESP.
- RESP: resp_valid=1 for exactly one cycle; req_ready=0. For loads, resp_rdata is the selected lane, sign- or zero-extended to 32 bits. Next state IDLE.
- Strobe and address rules:
  - mem_read and mem_write are decoded from the state register only and are never high together.
  - mem_addr is registered at accept and held stable from RD/WR through RESP.
- Latency from the accept edge to resp_valid:
  - Word load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word load: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- No response backpressure. req_valid is ignored outside IDLE. Back-to-back requests are accepted in the cycle after RESP.
- Little-endian: byte offset 0 is bits [7:0].

Test Plan:
- Store word 0xDEADBEEF at addr 0x010, then load word at 0x010: one WR cycle with mem_addr=4; load returns 0xDEADBEEF with error=0, 2 cycles after accept.
- Memory word 4 = 0xDEADBEEF; byte loads at 0x013 signed → 0xFFFFFFDE, 0x013 unsigned → 0x000000DE; half load at 0x012 signed → 0xFFFFDEAD, 0x010 unsigned → 0x0000BEEF.
- Byte store 0x55 at 0x011 over 0xDEADBEEF: RD then WR with mem_write_data=0xDEAD55EF; a following word load returns 0xDEAD55EF; resp comes 3 cycles after accept.
- Error cases, each giving a 1-cycle response with resp_error=1, resp_rdata=0 and no mem_read/mem_write ever high: word load at 0x002; half store at 0x005; size 11; addr 0x00001000 with MEM_AW=10.
- Reset mid-operation: pull rst_n low during WR of a sub-word store → mem_write falls asynchronously, no resp_valid, req_ready=1 after release; the next load completes normally.
- Strobe exclusivity: run randomized 200-request traffic checked against a reference byte-array model; mem_read&mem_write is never 1, and req_ready=0 whenever state≠IDLE.
